// File: rtl/apf_loader_pkg.sv
// rtl/apf_loader_pkg.sv - shared types and helpers for the ioctl ROM loader
package apf_loader_pkg;

    localparam int MAX_REGIONS = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_WRITE,
        ST_FLUSH,
        ST_DONE
    } state_t;

    // log2 of bytes per memory word (0, 1 or 2 for 8/16/32-bit words)
    function automatic int lane_bits(input int data_w);
        int n;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if ((1 << i) < (data_w / 8)) n = i + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/ioctl_rom_loader_if.sv
// rtl/ioctl_rom_loader_if.sv - host ioctl stream and memory write port bundle
interface ioctl_rom_loader_if #(
    parameter int NUM_REGIONS = 2,
    parameter int DATA_W      = 8,
    parameter int MEM_AW      = 13
);
    logic                   ioctl_download;
    logic [7:0]             ioctl_index;
    logic                   ioctl_wr;
    logic [24:0]            ioctl_addr;
    logic [7:0]             ioctl_dout;
    logic                   ioctl_wait;
    logic                   mem_we;
    logic [NUM_REGIONS-1:0] mem_sel;
    logic [MEM_AW-1:0]      mem_addr;
    logic [DATA_W-1:0]      mem_data;
    logic                   mem_ack;
    logic                   done;
    logic                   overflow;
    logic                   overrun;

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, mem_ack,
        output ioctl_wait, mem_we, mem_sel, mem_addr, mem_data, done, overflow, overrun
    );

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, mem_ack,
        input  ioctl_wait, mem_we, mem_sel, mem_addr, mem_data, done, overflow, overrun
    );
endinterface

// File: rtl/loader_region_match.sv
// rtl/loader_region_match.sv - map ioctl_index to a one-hot region, lowest match wins
module loader_region_match
    import apf_loader_pkg::*;
#(
    parameter int                         NUM_REGIONS  = 2,
    parameter logic [8*NUM_REGIONS-1:0]   REGION_INDEX = {8'd1, 8'd0}
) (
    input  logic [7:0]             i_index,
    output logic [NUM_REGIONS-1:0] o_sel,
    output logic                   o_valid
);

    localparam int N_CHECKED = (NUM_REGIONS > MAX_REGIONS) ? MAX_REGIONS : NUM_REGIONS;

    // Scan downwards so the lowest matching region is the last to overwrite
    always_comb begin
        o_sel   = '0;
        o_valid = 1'b0;
        for (int k = N_CHECKED - 1; k >= 0; k--) begin
            if (i_index == REGION_INDEX[8*k +: 8]) begin
                o_sel    = '0;
                o_sel[k] = 1'b1;
                o_valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ioctl_rom_loader.sv
// rtl/ioctl_rom_loader.sv - routes an ioctl download into packed memory words with host flow control
module ioctl_rom_loader
    import apf_loader_pkg::*;
#(
    parameter int                         NUM_REGIONS  = 2,
    parameter logic [8*NUM_REGIONS-1:0]   REGION_INDEX = {8'd1, 8'd0},
    parameter logic [32*NUM_REGIONS-1:0]  REGION_WORDS = {32'd4096, 32'd2048},
    parameter int                         DATA_W       = 8,
    parameter int                         MEM_AW       = 13,
    parameter logic [7:0]                 PAD_BYTE     = 8'hFF
) (
    input logic               clk_sys,
    input logic               reset,
    ioctl_rom_loader_if.slave bus
);

    localparam int BYTES = DATA_W / 8;
    localparam int LB    = lane_bits(DATA_W);
    localparam int LW    = (LB > 0) ? LB : 1;

    state_t                 r_state;
    state_t                 w_next;
    logic                   r_dl_q;
    logic                   r_fell;
    logic [NUM_REGIONS-1:0] r_sel;
    logic [31:0]            r_limit;
    logic [DATA_W-1:0]      r_buf;
    logic                   r_pend;
    logic [MEM_AW-1:0]      r_waddr;
    logic                   r_hold_v;
    logic [LW-1:0]          r_hold_lane;
    logic [7:0]             r_hold_byte;
    logic [MEM_AW-1:0]      r_hold_waddr;
    logic                   r_overflow;
    logic                   r_overrun;

    logic [NUM_REGIONS-1:0] w_match_sel;
    logic                   w_match_v;
    logic [31:0]            w_match_limit;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_ended;
    logic [LW-1:0]          w_lane;
    logic [24:0]            w_waddr_full;
    logic [MEM_AW-1:0]      w_waddr;
    logic                   w_in_range;
    logic                   w_same;
    logic                   w_last;
    logic                   w_hold_last;
    logic                   w_wr_live;
    logic                   w_take;
    logic                   w_busy;
    logic [DATA_W-1:0]      w_refill;

    loader_region_match #(
        .NUM_REGIONS  (NUM_REGIONS),
        .REGION_INDEX (REGION_INDEX)
    ) u_match (
        .i_index (bus.ioctl_index),
        .o_sel   (w_match_sel),
        .o_valid (w_match_v)
    );

    always_comb begin
        w_match_limit = '0;
        for (int k = 0; k < NUM_REGIONS; k++) begin
            if (w_match_sel[k]) w_match_limit = REGION_WORDS[32*k +: 32];
        end
    end

    generate
        if (BYTES == 1) begin : g_lane_byte
            assign w_lane = '0;
        end else begin : g_lane_wide
            assign w_lane = bus.ioctl_addr[LB-1:0];
        end
    endgenerate

    assign w_rise       = bus.ioctl_download & ~r_dl_q;
    assign w_fall       = ~bus.ioctl_download & r_dl_q;
    // r_fell keeps a fall seen mid-write so a quick re-rise cannot resume the old download
    assign w_ended      = r_fell | w_fall;
    assign w_waddr_full = bus.ioctl_addr >> LB;
    assign w_waddr      = w_waddr_full[MEM_AW-1:0];
    assign w_in_range   = {7'd0, w_waddr_full} < r_limit;
    assign w_same       = ~r_pend | (w_waddr == r_waddr);
    assign w_last       = (w_lane == LW'(BYTES - 1));
    assign w_hold_last  = (r_hold_lane == LW'(BYTES - 1));
    assign w_wr_live    = (r_state == ST_COLLECT) & bus.ioctl_wr & ~w_ended;
    assign w_take       = w_wr_live & w_in_range;
    assign w_busy       = (r_state == ST_WRITE) | (r_state == ST_FLUSH);

    // Next buffer contents after a commit: padding plus any byte parked behind the commit
    always_comb begin
        w_refill = {BYTES{PAD_BYTE}};
        if (r_hold_v) w_refill[r_hold_lane*8 +: 8] = r_hold_byte;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_rise && w_match_v) w_next = ST_COLLECT;
            end
            ST_COLLECT: begin
                if (w_ended)                          w_next = r_pend ? ST_FLUSH : ST_DONE;
                else if (w_take && (!w_same || w_last)) w_next = ST_WRITE;
            end
            ST_WRITE: begin
                if (bus.mem_ack) begin
                    if (r_hold_v && w_hold_last) w_next = ST_WRITE;
                    else if (w_ended)            w_next = r_hold_v ? ST_FLUSH : ST_DONE;
                    else                         w_next = ST_COLLECT;
                end
            end
            ST_FLUSH: begin
                if (bus.mem_ack) w_next = ST_DONE;
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_dl_q       <= 1'b1;
            r_fell       <= 1'b0;
            r_sel        <= '0;
            r_limit      <= '0;
            r_buf        <= {BYTES{PAD_BYTE}};
            r_pend       <= 1'b0;
            r_waddr      <= '0;
            r_hold_v     <= 1'b0;
            r_hold_lane  <= '0;
            r_hold_byte  <= '0;
            r_hold_waddr <= '0;
            r_overflow   <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_dl_q <= bus.ioctl_download;
            case (r_state)
                ST_IDLE: begin
                    if (w_rise && w_match_v) begin
                        r_sel      <= w_match_sel;
                        r_limit    <= w_match_limit;
                        r_overflow <= 1'b0;
                        r_overrun  <= 1'b0;
                        r_buf      <= {BYTES{PAD_BYTE}};
                        r_pend     <= 1'b0;
                        r_fell     <= 1'b0;
                        r_hold_v   <= 1'b0;
                        r_waddr    <= '0;
                    end
                end
                ST_COLLECT: begin
                    if (w_fall) r_fell <= 1'b1;
                    if (w_wr_live && !w_in_range) r_overflow <= 1'b1;
                    if (w_take) begin
                        if (w_same) begin
                            r_buf[w_lane*8 +: 8] <= bus.ioctl_dout;
                            r_waddr              <= w_waddr;
                            r_pend               <= 1'b1;
                        end else begin
                            r_hold_v     <= 1'b1;
                            r_hold_lane  <= w_lane;
                            r_hold_byte  <= bus.ioctl_dout;
                            r_hold_waddr <= w_waddr;
                        end
                    end
                end
                ST_WRITE, ST_FLUSH: begin
                    if (w_fall) r_fell <= 1'b1;
                    if (bus.ioctl_wr) r_overrun <= 1'b1;
                    if (bus.mem_ack) begin
                        r_buf    <= w_refill;
                        r_pend   <= r_hold_v;
                        r_hold_v <= 1'b0;
                        if (r_hold_v) r_waddr <= r_hold_waddr;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ioctl_wait = w_busy;
    assign bus.mem_we     = w_busy;
    assign bus.mem_sel    = w_busy ? r_sel : '0;
    assign bus.mem_addr   = w_busy ? r_waddr : '0;
    assign bus.mem_data   = w_busy ? r_buf : '0;
    assign bus.done       = (r_state == ST_DONE);
    assign bus.overflow   = r_overflow;
    assign bus.overrun    = r_overrun;

endmodule

// File: tb/tb_ioctl_rom_loader.sv
// tb/tb_ioctl_rom_loader.sv - scoreboard bench for ioctl_rom_loader with 16-bit words
module tb_ioctl_rom_loader;

    localparam int NR = 2;
    localparam int DW = 16;
    localparam int AW = 13;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ioctl_rom_loader_if #(.NUM_REGIONS(NR), .DATA_W(DW), .MEM_AW(AW)) bus();

    ioctl_rom_loader #(
        .NUM_REGIONS  (NR),
        .REGION_INDEX ({8'd1, 8'd0}),
        .REGION_WORDS ({32'd4096, 32'd2048}),
        .DATA_W       (DW),
        .MEM_AW       (AW),
        .PAD_BYTE     (8'hFF)
    ) dut (
        .clk_sys (clk),
        .reset   (reset),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [30:0] exp_q[$];
    int          done_q[$];
    int          ack_delay = 0;
    bit          chk_wait  = 0;
    bit          wait_seen = 0;

    bit          m_active = 0;
    logic [1:0]  m_sel;
    int          m_limit;
    int          m_cur;
    logic [7:0]  m_lane[2];
    logic [1:0]  m_written;
    bit          m_ovf;
    bit          m_ovr;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word();
        exp_q.push_back({m_sel, 13'(m_cur),
                         m_written[1] ? m_lane[1] : 8'hFF,
                         m_written[0] ? m_lane[0] : 8'hFF});
        m_written = 2'b00;
    endtask

    // Reference: bytes pack by word address; a full word or a word change commits
    task automatic model_byte(input int addr, input logic [7:0] data);
        int w;
        int l;
        w = addr / 2;
        l = addr % 2;
        if (!m_active) return;
        if (w >= m_limit) begin
            m_ovf = 1;
            return;
        end
        if (m_written != 2'b00 && w != m_cur) push_word();
        m_cur = w;
        m_lane[l] = data;
        m_written[l] = 1'b1;
        if (l == 1) push_word();
    endtask

    task automatic start_dl(input logic [7:0] idx);
        bus.ioctl_index    = idx;
        bus.ioctl_download = 1'b1;
        m_active  = (idx == 8'd0) || (idx == 8'd1);
        m_sel     = (idx == 8'd0) ? 2'b01 : 2'b10;
        m_limit   = (idx == 8'd0) ? 2048 : 4096;
        m_written = 2'b00;
        m_cur     = -1;
        m_ovf     = 0;
        m_ovr     = 0;
        tick();
        tick();
    endtask

    task automatic send_byte(input int addr, input logic [7:0] data);
        int guard;
        guard = 0;
        while (bus.ioctl_wait && guard < 200) begin
            tick();
            guard++;
        end
        if (guard >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_release: ioctl_wait still %0b after %0d cycles, required 0", bus.ioctl_wait, guard);
        end
        bus.ioctl_addr = 25'(addr);
        bus.ioctl_dout = data;
        bus.ioctl_wr   = 1'b1;
        tick();
        bus.ioctl_wr   = 1'b0;
        model_byte(addr, data);
    endtask

    task automatic end_dl(input bit chk_latency);
        int guard;
        bus.ioctl_download = 1'b0;
        if (m_active) begin
            if (m_written != 2'b00) push_word();
            done_q.push_back(1);
        end
        if (chk_latency) begin
            tick();
            check("done_latency", bus.done, 1);
        end
        guard = 0;
        while ((done_q.size() != 0 || exp_q.size() != 0) && guard < 200) begin
            tick();
            guard++;
        end
        if (guard >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL download_drain: %0d writes and %0d done pulses outstanding, required 0", exp_q.size(), done_q.size());
        end
        repeat (3) tick();
        if (m_active) check("flags", {bus.overflow, bus.overrun}, {m_ovf, m_ovr});
        m_active = 0;
    endtask

    // Memory responder: fixed or random ack delay per word
    initial begin
        int cnt;
        int d;
        cnt = 0;
        d = 0;
        bus.mem_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (reset || !bus.mem_we) begin
                bus.mem_ack = 1'b0;
                cnt = 0;
            end else begin
                if (bus.mem_ack) cnt = 0;
                if (cnt == 0) d = (ack_delay >= 0) ? ack_delay : int'($urandom_range(0, 3));
                bus.mem_ack = (cnt >= d);
                cnt++;
            end
        end
    end

    // Monitor: pops expected words on accepted writes and expected done pulses
    initial begin
        logic        prev_we;
        logic        prev_ack;
        logic        prev_done;
        logic [30:0] prev_word;
        logic [30:0] word;
        int          wait_run;
        prev_we = 0; prev_ack = 0; prev_done = 0; prev_word = '0; wait_run = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_we = 0; prev_ack = 0; prev_done = 0; wait_run = 0;
            end else begin
                word = {bus.mem_sel, bus.mem_addr, bus.mem_data};
                if (bus.ioctl_wait) begin
                    wait_seen = 1;
                    wait_run++;
                end else begin
                    if (wait_run > 0 && chk_wait) check("wait_cycles", wait_run, ack_delay + 1);
                    wait_run = 0;
                end
                if (bus.mem_we) begin
                    if (prev_we && !prev_ack) check("word_stable", word, prev_word);
                    if (bus.mem_ack) begin
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL write_expected: got write %0h, required no write", word);
                        end else begin
                            check("write", word, exp_q.pop_front());
                        end
                    end
                end
                if (bus.done) begin
                    check("done_width", prev_done, 0);
                    if (done_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL done_expected: got done pulse, required none");
                    end else begin
                        void'(done_q.pop_front());
                        check("writes_before_done", exp_q.size(), 0);
                    end
                end
                prev_word = word;
                prev_we   = bus.mem_we;
                prev_ack  = bus.mem_ack;
                prev_done = bus.done;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int addr;
        int r;
        int n;
        bus.ioctl_download = 1'b0;
        bus.ioctl_index    = 8'd0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = '0;
        repeat (3) tick();
        check("reset_outputs", {bus.mem_we, bus.ioctl_wait, bus.done, bus.overflow, bus.overrun,
                                bus.mem_sel, bus.mem_addr, bus.mem_data}, 0);
        reset = 1'b0;
        tick();
        check("idle_outputs", {bus.mem_we, bus.ioctl_wait, bus.done, bus.overflow, bus.overrun}, 0);

        // Immediate ack: one full word, one-cycle wait, done right after the fall
        ack_delay = 0; chk_wait = 1;
        start_dl(8'd0);
        send_byte(0, 8'h11);
        send_byte(1, 8'h22);
        end_dl(1);

        // Delayed ack with a trailing partial word flushed with padding
        ack_delay = 3;
        start_dl(8'd1);
        send_byte(0, 8'hAA);
        send_byte(1, 8'hBB);
        send_byte(2, 8'hCC);
        end_dl(0);

        // Unmatched index: stream ignored entirely
        wait_seen = 0;
        start_dl(8'd5);
        send_byte(0, 8'h01);
        send_byte(1, 8'h02);
        end_dl(0);
        check("nomatch_wait", wait_seen, 0);

        // Byte past the end of region 0, then the next start clears overflow
        ack_delay = 0;
        start_dl(8'd0);
        send_byte(4096, 8'h77);
        end_dl(0);
        start_dl(8'd0);
        check("overflow_cleared", bus.overflow, 0);
        send_byte(6, 8'h31);
        send_byte(7, 8'h32);
        end_dl(0);

        // Strobe while the host is stalled: dropped, sticky overrun
        ack_delay = 3;
        start_dl(8'd1);
        send_byte(0, 8'h12);
        send_byte(1, 8'h34);
        check("wait_during_write", bus.ioctl_wait, 1);
        bus.ioctl_addr = 25'd0;
        bus.ioctl_dout = 8'h99;
        bus.ioctl_wr   = 1'b1;
        tick();
        bus.ioctl_wr   = 1'b0;
        m_ovr = 1;
        end_dl(0);

        // Reset in the middle of a write aborts everything
        ack_delay = 20; chk_wait = 0;
        start_dl(8'd0);
        send_byte(0, 8'h5A);
        send_byte(1, 8'hA5);
        tick();
        reset = 1'b1;
        exp_q.delete();
        done_q.delete();
        m_active = 0;
        tick();
        check("reset_mid_write", {bus.mem_we, bus.ioctl_wait, bus.done}, 0);
        bus.ioctl_download = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        ack_delay = 0;
        start_dl(8'd0);
        send_byte(0, 8'hC3);
        send_byte(1, 8'h3C);
        end_dl(0);

        // Random downloads: random index, ack latency, and address jumps
        ack_delay = -1;
        for (int t = 0; t < 12; t++) begin
            r = int'($urandom_range(0, 4));
            start_dl((r < 2) ? 8'd0 : (r < 4) ? 8'd1 : 8'd5);
            n = int'($urandom_range(1, 12));
            addr = int'($urandom_range(0, 40));
            for (int i = 0; i < n; i++) begin
                send_byte(addr, 8'($urandom));
                addr = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 9000)) : addr + 1;
            end
            end_dl(0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
